// File: rtl/vc_tx_scheduler_if.sv
// Link between the per-VC transmit queues and the router input port:
// queue fronts, pop strobes, credit returns and the registered flit output.
interface vc_tx_scheduler_if #(
  parameter int N_VIRT_CHN = 3,
  parameter int FLIT_WIDTH = 34,
  parameter int VC_WIDTH   = $clog2(N_VIRT_CHN)
);
  logic [N_VIRT_CHN-1:0]            vc_valid;
  logic [N_VIRT_CHN*FLIT_WIDTH-1:0] vc_flit;
  logic [N_VIRT_CHN-1:0]            vc_ready;
  logic [N_VIRT_CHN-1:0]            credit_in;
  logic                             out_valid;
  logic [FLIT_WIDTH-1:0]            out_flit;
  logic [VC_WIDTH-1:0]              out_vc_id;

  // master: queue/router side that feeds the scheduler
  modport master (
    output vc_valid, vc_flit, credit_in,
    input  vc_ready, out_valid, out_flit, out_vc_id
  );

  modport slave (
    input  vc_valid, vc_flit, credit_in,
    output vc_ready, out_valid, out_flit, out_vc_id
  );
endinterface

// File: rtl/vc_tx_scheduler.sv
// Virtual-channel transmit scheduler: packet-locked round-robin grant of VC
// queue fronts onto one router link, gated by per-VC downstream credits.
module vc_tx_scheduler #(
  parameter int N_VIRT_CHN    = 3,
  parameter int FLIT_WIDTH    = 34,
  parameter int FLIT_TP_WIDTH = 2,
  parameter int CREDITS       = 4,
  parameter int VC_WIDTH      = $clog2(N_VIRT_CHN)
) (
  input  logic               clk,
  input  logic               arst,
  vc_tx_scheduler_if.slave   bus,
  output logic               lock_o,
  output logic               err_o
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [FLIT_TP_WIDTH-1:0] TP_HEAD = FLIT_TP_WIDTH'(0);
  localparam logic [FLIT_TP_WIDTH-1:0] TP_TAIL = FLIT_TP_WIDTH'(2);
  localparam logic [FLIT_TP_WIDTH-1:0] TP_HT   = FLIT_TP_WIDTH'(3);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                   state, state_nxt;
  logic [VC_WIDTH-1:0]      rr_ptr, lock_vc;
  logic [CW-1:0]            cnt [N_VIRT_CHN];

  logic [FLIT_TP_WIDTH-1:0] ftype [N_VIRT_CHN];
  logic [N_VIRT_CHN-1:0]    elig, is_head, cnt_full, ready, send;
  logic                     grant_hit, idle_err, lock_err, cred_err, xfer, rr_load;
  logic [VC_WIDTH-1:0]      grant_vc, sel_vc;
  logic [VC_WIDTH:0]        scan;
  logic [FLIT_TP_WIDTH-1:0] sel_type;
  logic [FLIT_WIDTH-1:0]    sel_flit;

  function automatic logic [VC_WIDTH-1:0] next_vc(input logic [VC_WIDTH-1:0] v);
    return (v == VC_WIDTH'(N_VIRT_CHN - 1)) ? '0 : v + VC_WIDTH'(1);
  endfunction

  // Eligibility uses the registered count, so a credit returned this cycle
  // only takes effect next cycle.
  always_comb begin
    for (int i = 0; i < N_VIRT_CHN; i++) begin
      ftype[i]    = bus.vc_flit[i*FLIT_WIDTH + FLIT_WIDTH - 1 -: FLIT_TP_WIDTH];
      is_head[i]  = (ftype[i] == TP_HEAD) || (ftype[i] == TP_HT);
      elig[i]     = bus.vc_valid[i] && (cnt[i] != '0);
      cnt_full[i] = (cnt[i] == CW'(CREDITS));
    end
  end

  // Round-robin scan from rr_ptr; eligible non-head fronts are skipped.
  always_comb begin
    // NOTE: every signal gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    grant_hit = 1'b0;
    grant_vc  = '0;
    idle_err  = 1'b0;
    scan      = '0;
    for (int k = 0; k < N_VIRT_CHN; k++) begin
      scan = {1'b0, rr_ptr} + (VC_WIDTH+1)'(k);
      if (scan >= (VC_WIDTH+1)'(N_VIRT_CHN)) scan = scan - (VC_WIDTH+1)'(N_VIRT_CHN);
      if (elig[scan[VC_WIDTH-1:0]]) begin
        if (!is_head[scan[VC_WIDTH-1:0]]) begin
          idle_err = 1'b1;
        end else if (!grant_hit) begin
          grant_hit = 1'b1;
          grant_vc  = scan[VC_WIDTH-1:0];
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer && sel_type == TP_HEAD) state_nxt = LOCKED;
      LOCKED:  if (xfer && sel_type == TP_TAIL) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: pop strobes, selected VC and error sources
  always_comb begin
    ready    = '0;
    sel_vc   = lock_vc;
    lock_err = 1'b0;
    lock_o   = (state == LOCKED);
    case (state)
      IDLE: begin
        if (grant_hit) begin
          ready[grant_vc] = 1'b1;
          sel_vc          = grant_vc;
        end
      end
      LOCKED: begin
        // A new head while locked means the upstream lost a tail.
        if (bus.vc_valid[lock_vc] && is_head[lock_vc]) lock_err = 1'b1;
        else                                          ready[lock_vc] = elig[lock_vc];
      end
      default: ;
    endcase
    if (arst) ready = '0;
  end

  assign bus.vc_ready = ready;
  assign send         = bus.vc_valid & ready;
  assign xfer         = |send;
  assign sel_type     = ftype[sel_vc];
  assign sel_flit     = bus.vc_flit[sel_vc*FLIT_WIDTH +: FLIT_WIDTH];
  assign cred_err     = |(bus.credit_in & ~send & cnt_full);
  assign rr_load      = xfer && (((state == IDLE) && (sel_type == TP_HT)) ||
                                 ((state == LOCKED) && (sel_type == TP_TAIL)));

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rr_ptr    <= '0;
      lock_vc   <= '0;
      out_reset();
      err_o     <= 1'b0;
      // NOTE: the credit array is a handful of flops, not a RAM, so it takes
      // the async reset like any other state.
      for (int i = 0; i < N_VIRT_CHN; i++) cnt[i] <= CW'(CREDITS);
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed by the combinational logic.
      if (rr_load) rr_ptr <= next_vc(sel_vc);
      if (state == IDLE && state_nxt == LOCKED) lock_vc <= sel_vc;

      bus.out_valid <= xfer;
      if (xfer) begin
        bus.out_flit  <= sel_flit;
        bus.out_vc_id <= sel_vc;
      end

      err_o <= err_o | ((state == IDLE) && idle_err) | lock_err | cred_err;

      for (int i = 0; i < N_VIRT_CHN; i++) begin
        case ({send[i], bus.credit_in[i]})
          2'b10:   cnt[i] <= cnt[i] - CW'(1);
          2'b01:   if (!cnt_full[i]) cnt[i] <= cnt[i] + CW'(1);
          default: ;
        endcase
      end
    end
  end

  task automatic out_reset();
    bus.out_valid <= 1'b0;
    bus.out_flit  <= '0;
    bus.out_vc_id <= '0;
  endtask

endmodule

// File: tb/tb_vc_tx_scheduler.sv
// Directed bench for vc_tx_scheduler: upstream VC queues modelled in the bench,
// expected link output held in a scoreboard queue filled when stimulus is loaded.
module tb_vc_tx_scheduler;
  localparam int N  = 3;
  localparam int FW = 34;
  localparam int VW = 2;
  localparam int CR = 4;
  localparam logic [1:0] HEAD = 2'b00, BODY = 2'b01, TAIL = 2'b10, HT = 2'b11;

  typedef struct {
    logic [VW-1:0] vc;
    logic [FW-1:0] flit;
  } exp_t;

  logic clk = 1'b0;
  logic arst = 1'b1;
  logic lock_o, err_o;

  vc_tx_scheduler_if #(.N_VIRT_CHN(N), .FLIT_WIDTH(FW)) bus ();

  vc_tx_scheduler #(
    .N_VIRT_CHN(N), .FLIT_WIDTH(FW), .FLIT_TP_WIDTH(2), .CREDITS(CR)
  ) dut (
    .clk    (clk),
    .arst   (arst),
    .bus    (bus),
    .lock_o (lock_o),
    .err_o  (err_o)
  );

  always #5 clk = ~clk;

  logic [FW-1:0] vq [N][$];
  exp_t          sb [$];
  int            n_assert = 0;
  int            n_fail   = 0;
  int            seq      = 0;
  logic [N-1:0]  last_ready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_flit(input int vc, input logic [1:0] tp, input bit expect_out);
    logic [FW-1:0] f;
    exp_t e;
    seq++;
    f = {tp, 8'(vc), 24'(seq)};
    vq[vc].push_back(f);
    if (expect_out) begin
      e.vc   = VW'(vc);
      e.flit = f;
      sb.push_back(e);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.vc_valid[i] = (vq[i].size() != 0);
      bus.vc_flit[i*FW +: FW] = (vq[i].size() != 0) ? vq[i][0] : '0;
    end
  endtask

  // One clock: sample pop strobes mid-cycle, advance the upstream queues after
  // the edge, then score whatever the link registered.
  task automatic cycle();
    logic [N-1:0] pop;
    exp_t e;
    @(negedge clk);
    last_ready = bus.vc_ready;
    pop = bus.vc_ready & bus.vc_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (pop[i]) void'(vq[i].pop_front());
    bus.credit_in = '0;
    drive();
    if (bus.out_valid === 1'b1) begin
      check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_vc_id", 64'(bus.out_vc_id), 64'(e.vc));
        check("out_flit", 64'(bus.out_flit), 64'(e.flit));
      end
    end
  endtask

  task automatic check_cnts(input string tag, input int exp);
    for (int i = 0; i < N; i++) check(tag, 64'(dut.cnt[i]), 64'(exp));
  endtask

  initial begin
    bus.vc_valid  = '0;
    bus.vc_flit   = '0;
    bus.credit_in = '0;

    // Fairness stimulus is queued during reset: pops must stay suppressed.
    for (int r = 0; r < 2; r++)
      for (int v = 0; v < N; v++) push_flit(v, HT, 1'b1);
    drive();
    repeat (2) @(posedge clk);
    #1;
    check("rst_vc_ready", 64'(bus.vc_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_flit", 64'(bus.out_flit), 64'd0);
    check("rst_out_vc_id", 64'(bus.out_vc_id), 64'd0);
    check("rst_lock", 64'(lock_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check_cnts("rst_cnt", CR);
    arst = 1'b0;

    // Single-flit fairness: 0,1,2,0,1,2 back to back
    for (int c = 0; c < 6; c++) begin
      cycle();
      check("rr_contig_valid", 64'(bus.out_valid), 64'd1);
    end
    cycle();
    check("rr_idle_after", 64'(bus.out_valid), 64'd0);
    check_cnts("rr_cnt_end", 2);
    check("rr_err", 64'(err_o), 64'd0);
    repeat (2) begin
      bus.credit_in = 3'b111;
      cycle();
    end
    check_cnts("rr_cnt_refill", CR);

    // Move rr_ptr to VC1 with one extra single-flit packet from VC0
    push_flit(0, HT, 1'b1);
    drive();
    cycle();
    bus.credit_in = 3'b001;
    cycle();

    // Packet lock: 1,1,1,1 then 2 then 0; lock_o for the 3 cycles after HEAD
    push_flit(1, HEAD, 1'b1);
    push_flit(1, BODY, 1'b1);
    push_flit(1, BODY, 1'b1);
    push_flit(1, TAIL, 1'b1);
    push_flit(2, HT, 1'b1);
    push_flit(0, HT, 1'b1);
    drive();
    check("lock_before", 64'(lock_o), 64'd0);
    for (int c = 0; c < 6; c++) begin
      cycle();
      check("lock_valid", 64'(bus.out_valid), 64'd1);
      check("lock_o", 64'(lock_o), 64'(c < 3));
    end
    bus.credit_in = 3'b111;
    cycle();
    repeat (3) begin
      bus.credit_in = 3'b010;
      cycle();
    end
    check_cnts("lock_cnt_refill", CR);

    // Credit stall: six-flit packet on VC0 with four credits
    push_flit(0, HEAD, 1'b1);
    for (int b = 0; b < 4; b++) push_flit(0, BODY, 1'b1);
    push_flit(0, TAIL, 1'b1);
    drive();
    for (int c = 0; c < 4; c++) begin
      cycle();
      check("stall_pop", 64'(last_ready[0]), 64'd1);
    end
    repeat (2) begin
      cycle();
      check("stall_ready0", 64'(last_ready[0]), 64'd0);
      check("stall_no_out", 64'(bus.out_valid), 64'd0);
    end
    repeat (2) begin
      bus.credit_in = 3'b001;
      cycle();
      check("credit_same_cycle", 64'(last_ready[0]), 64'd0);
      cycle();
      check("credit_next_pop", 64'(last_ready[0]), 64'd1);
      check("credit_next_out", 64'(bus.out_valid), 64'd1);
    end
    check("stall_drained", 64'(vq[0].size()), 64'd0);
    check("stall_unlocked", 64'(lock_o), 64'd0);

    // Send and credit return in the same cycle with cnt[0]=1
    bus.credit_in = 3'b001;
    cycle();
    check("sim_cnt_one", 64'(dut.cnt[0]), 64'd1);
    push_flit(0, HEAD, 1'b1);
    push_flit(0, TAIL, 1'b1);
    drive();
    bus.credit_in = 3'b001;
    cycle();
    check("sim_pop_head", 64'(last_ready[0]), 64'd1);
    check("sim_cnt_hold", 64'(dut.cnt[0]), 64'd1);
    cycle();
    check("sim_pop_tail", 64'(last_ready[0]), 64'd1);
    check("sim_tail_out", 64'(bus.out_valid), 64'd1);
    repeat (4) begin
      bus.credit_in = 3'b001;
      cycle();
    end
    check("sim_cnt_refill", 64'(dut.cnt[0]), 64'(CR));

    // Reset mid-packet after HEAD and one BODY on VC0
    push_flit(0, HEAD, 1'b1);
    push_flit(0, BODY, 1'b1);
    push_flit(0, BODY, 1'b0);
    push_flit(0, TAIL, 1'b0);
    drive();
    cycle();
    cycle();
    check("mid_locked", 64'(lock_o), 64'd1);
    arst = 1'b1;
    #1;
    check("mid_rst_ready", 64'(bus.vc_ready), 64'd0);
    check("mid_rst_lock", 64'(lock_o), 64'd0);
    vq[0].delete();
    for (int v = 0; v < N; v++) push_flit(v, HT, 1'b1);
    drive();
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b0;
    check("mid_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_lock", 64'(lock_o), 64'd0);
    check_cnts("mid_cnt", CR);
    // Scan restarts at VC0: scoreboard expects 0,1,2
    repeat (3) cycle();

    // BODY at VC2 front while IDLE: skipped and flagged
    check("err_clear", 64'(err_o), 64'd0);
    push_flit(2, BODY, 1'b0);
    drive();
    cycle();
    check("body_not_popped", 64'(last_ready), 64'd0);
    check("body_no_out", 64'(bus.out_valid), 64'd0);
    check("body_err", 64'(err_o), 64'd1);

    // Credit overflow on VC1 at full count
    arst = 1'b1;
    vq[2].delete();
    drive();
    @(posedge clk);
    #1;
    arst = 1'b0;
    check("err_after_rst", 64'(err_o), 64'd0);
    bus.credit_in = 3'b010;
    cycle();
    check("ovf_err", 64'(err_o), 64'd1);
    check("ovf_cnt", 64'(dut.cnt[1]), 64'(CR));

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vc_tx_scheduler.md
# vc_tx_scheduler

Schedules flits from the per-virtual-channel transmit queues of the network interface onto the single router input link. It grants one VC at a time with packet-level locking and round-robin between packets. It tracks per-VC downstream buffer credits so that no flit is sent without space in the router's VC buffer. It sits between the packet generator's VC queues and the local router input port.

## Interface
- N_VIRT_CHN, 3: number of virtual channels; must be at least 2.
- FLIT_WIDTH, 34: full flit width; flit type is in bits [FLIT_WIDTH-1 -: FLIT_TP_WIDTH].
- FLIT_TP_WIDTH, 2: flit type field width.
  - Encoding: 2'b00 HEAD, 2'b01 BODY, 2'b10 TAIL, 2'b11 HEAD_TAIL (single-flit packet).
- CREDITS, 4: downstream buffer slots per VC; the credit counter width is CW = $clog2(CREDITS+1).
- VC_WIDTH, $clog2(N_VIRT_CHN): derived.

Ports:
- clk  in  1  clock.
- arst  in  1  reset, asynchronous, active-high.
- vc_valid  in  N_VIRT_CHN  VC i has a flit at its queue front.
- vc_flit  in  N_VIRT_CHN*FLIT_WIDTH  front flit of VC i, at slice [i*FLIT_WIDTH +: FLIT_WIDTH].
- vc_ready  out  N_VIRT_CHN  pop strobe to VC i; combinational, one-hot or zero.
- out_valid  out  1  flit valid on the router link; registered.
- out_flit  out  FLIT_WIDTH  flit to the router; registered.
- out_vc_id  out  VC_WIDTH  VC of out_flit; registered.
- credit_in  in  N_VIRT_CHN  one-cycle pulse per freed downstream slot of VC i.
- lock_o  out  1  high while in LOCKED.
- err_o  out  1  sticky protocol-error flag.

## Operation
- Credit counters cnt[i]:
  - Reset value is CREDITS.
  - Send only (vc_valid[i]&vc_ready[i]): decrement by 1.
  - credit_in[i] only: increment by 1.
  - Send and credit_in[i] in the same cycle: unchanged.
  - credit_in[i] while cnt[i]==CREDITS and no send that cycle: counter holds, err_o <= 1.
- Eligibility: elig[i] = vc_valid[i] && cnt[i]!=0, using the registered count.
  - A credit_in[i] arriving in a cycle does not make VC i eligible in that same cycle.
- State machine (IDLE, LOCKED), with registers rr_ptr and lock_vc.
- IDLE:
  - Grant g is the first i with elig[i], scanning rr_ptr, rr_ptr+1, … modulo N_VIRT_CHN.
  - A VC is grantable only if its front flit type is HEAD or HEAD_TAIL.
  - A VC that is eligible but whose front is BODY or TAIL is skipped and sets err_o.
  - vc_ready[g]=1.
  - HEAD transferred: go to LOCKED, lock_vc<=g.
  - HEAD_TAIL transferred: stay in IDLE, rr_ptr<=(g+1) mod N.
  - No grant: nothing changes.
- LOCKED:
  - vc_ready[lock_vc] = elig[lock_vc]; all other vc_ready are 0.
  - BODY transferred: stay in LOCKED.
  - TAIL transferred: go to IDLE, rr_ptr<=(lock_vc+1) mod N.
  - Front flit of HEAD or HEAD_TAIL: not popped (vc_ready=0), err_o<=1, state holds.
    - Recovery is by reset only.
- Output register on each transfer:
  - out_valid<=1, out_flit<=the granted flit unmodified, out_vc_id<=the granted VC.
  - Otherwise out_valid<=0, and out_flit/out_vc_id hold their previous values.
- err_o clears only on reset.
- Reset values:
  - State IDLE, rr_ptr 0, lock_vc 0, all cnt[i]=CREDITS.
  - out_valid 0, out_flit 0, out_vc_id 0, lock_o 0, err_o 0.
  - vc_ready is forced to 0 while arst is high.

## Timing
- Throughput is one flit per cycle, including back-to-back packets and HEAD then BODY on the same VC.
- Latency: a flit popped at edge k has out_valid high during cycle k+1 (one register stage).
- The router link has no backpressure; credits are the only flow control.
- Credit return latency: credit_in high at edge k makes the VC eligible in cycle k+1.
- Round-robin update applies at the edge of the HEAD_TAIL/TAIL transfer. The next arbitration, in the following cycle, uses the new rr_ptr.
- LOCKED→IDLE→new grant takes no bubble: the TAIL at edge k can be followed by another VC's HEAD at edge k+1.
- Reset mid-packet:
  - Drops the lock and restores all credits.
  - out_valid is 0 on the first cycle after arst deasserts.
  - The upstream queue is not rewound.

## Test plan
- Single-flit fairness: N=3; all three VCs each hold 2 HEAD_TAIL flits; no credit_in.
  - Required out_vc_id sequence: 0,1,2,0,1,2 on consecutive cycles.
  - All cnt end at 2; err_o=0.
- Packet lock: VC1 sends HEAD,BODY,BODY,TAIL while VC0 and VC2 hold HEAD_TAIL.
  - Required out_vc_id sequence: 1,1,1,1 contiguous, then 2, then 0.
  - lock_o is high for exactly the 3 cycles after the HEAD pop.
- Credit stall: CREDITS=4; VC0 sends a 6-flit packet with no credit_in.
  - 4 flits go out, then vc_ready[0] stays 0.
  - A credit_in[0] pulse at edge k gives a pop at edge k+1.
  - Two pulses are needed to finish the packet.
- Simultaneous credit and send: cnt[0]=1; a send and credit_in[0] occur in the same cycle.
  - cnt[0] stays 1, and the next flit is sent the following cycle.
- Errors:
  - A BODY flit at the VC2 front while IDLE: not popped, err_o=1.
  - credit_in[1] while cnt[1]=4: err_o=1, cnt[1]=4.
- Reset mid-packet: assert arst after the HEAD and 1 BODY on VC0.
  - Required after reset: lock_o=0, all cnt=4, out_valid=0.
  - The next grant starts the scan at VC0.
